wr_data_conv: RTL and testbench

- Converts the mcd write data path into the SATA HBA write data path.
- Each write command's word count is queued through num_words and rd_num_words-style enable.
- Passes exactly num_words 32-bit words from mcd to the HBA write FIFO, then zero-pads to the next 128-word (512 B sector) boundary.
- Sits between McdCmdAdapter/mcd and the HBA write FIFO.

---
 rtl/wr_data_conv_pkg.sv | 29 ++
 rtl/wr_data_conv_reg_fifo.sv | 69 ++++++
 rtl/wr_data_conv.sv | 148 ++++++++++++++
 tb/tb_wr_data_conv.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wr_data_conv_pkg.sv
// Shared definitions for the mcd -> SATA HBA write data converter.
//   - default geometry (data width, sector size, num_words queue depth)
//   - FSM state encoding
//   - word counter width and the sector-boundary helper
package wr_data_conv_pkg;

  localparam int unsigned DATA_BITS_DEF     = 32;
  localparam int unsigned SECTOR_LOG2_DEF   = 7;
  localparam int unsigned NW_DEPTH_BITS_DEF = 4;
  localparam int unsigned NW_BITS           = 16;
  // One bit wider than num_words so a 65535-word command pads to 65536.
  localparam int unsigned CNT_W             = 17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PASS = 2'd2,
    ST_PAD  = 2'd3
  } state_e;

  // True when the low log2 bits of cnt are all zero (sector boundary).
  function automatic logic sector_end(input logic [CNT_W-1:0] cnt,
                                      input int unsigned      log2);
    logic [CNT_W-1:0] mask;
    mask = (CNT_W'(1) << log2) - CNT_W'(1);
    return (cnt & mask) == '0;
  endfunction

endpackage

// File: rtl/wr_data_conv_reg_fifo.sv
// reg_fifo: small register-based FIFO (used for the num_words queue).
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   wr_en, wr_data  enqueue request / payload
//   rd_en           dequeue request (ignored when empty)
//   rd_data         head entry (valid when !empty)
//   full, empty     status
// An enqueue while full is accepted if a dequeue happens in the same cycle.
module reg_fifo #(
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;

  logic [DATA_BITS-1:0]  mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  push, pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign pop     = rd_en & ~empty;
  assign push    = wr_en & (~full | pop);

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_BITS'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy qualifies every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/wr_data_conv.sv
// wr_data_conv: moves each write command's num_words data words from mcd to
// the HBA write FIFO, then zero-pads up to the next sector boundary.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   dramWrData_data/_valid/_ready      mcd write data handshake
//   wdata, wdata_write, wdata_full     HBA write FIFO push interface
//   link_initialized                   0 stalls every transfer
//   num_words, wr_num_words_en         per-command word count enqueue
//   nw_overflow                        sticky: a count was dropped (queue full)
//   fin_write                          pulse: last padded word of a command loaded
//   curr_state_de, curr_words_de       debug state / word counter
module wr_data_conv
  import wr_data_conv_pkg::*;
#(
  parameter int unsigned DATA_BITS     = DATA_BITS_DEF,
  parameter int unsigned SECTOR_LOG2   = SECTOR_LOG2_DEF,
  parameter int unsigned NW_DEPTH_BITS = NW_DEPTH_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] dramWrData_data,
  input  logic                 dramWrData_valid,
  output logic                 dramWrData_ready,
  output logic [DATA_BITS-1:0] wdata,
  output logic                 wdata_write,
  input  logic                 wdata_full,
  input  logic                 link_initialized,
  input  logic [NW_BITS-1:0]   num_words,
  input  logic                 wr_num_words_en,
  output logic                 nw_overflow,
  output logic                 fin_write,
  output logic [1:0]           curr_state_de,
  output logic [CNT_W-1:0]     curr_words_de
);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0]     curr_words_q, curr_words_d;
  logic [NW_BITS-1:0]   num_words_q, num_words_d;
  logic                 fin_write_q, fin_write_d;
  logic                 nw_overflow_q, nw_overflow_d;

  logic                 nw_pop, nw_full, nw_empty;
  logic [NW_BITS-1:0]   nw_head;
  logic                 space, accept;
  logic [CNT_W-1:0]     words_inc;

  reg_fifo #(
    .DATA_BITS  (NW_BITS),
    .DEPTH_BITS (NW_DEPTH_BITS)
  ) u_nw_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_num_words_en),
    .wr_data (num_words),
    .rd_en   (nw_pop),
    .rd_data (nw_head),
    .full    (nw_full),
    .empty   (nw_empty)
  );

  // Holding register drains whenever the HBA FIFO can take it and the link is up.
  assign wdata_write      = hold_valid_q & ~wdata_full & link_initialized;
  assign space            = ~hold_valid_q | wdata_write;
  assign dramWrData_ready = (state_q == ST_PASS) & space & link_initialized;
  assign accept           = dramWrData_valid & dramWrData_ready;
  assign nw_pop           = (state_q == ST_LOAD);
  assign words_inc        = curr_words_q + CNT_W'(1);

  assign wdata            = hold_data_q;
  assign fin_write        = fin_write_q;
  assign nw_overflow      = nw_overflow_q;
  assign curr_state_de    = state_q;
  assign curr_words_de    = curr_words_q;

  // Next-state, holding register and counter logic.
  always_comb begin
    state_d       = state_q;
    hold_data_d   = hold_data_q;
    hold_valid_d  = hold_valid_q & ~wdata_write;
    curr_words_d  = curr_words_q;
    num_words_d   = num_words_q;
    fin_write_d   = 1'b0;
    // A dequeue in the same cycle frees a slot, so only a true drop is sticky.
    nw_overflow_d = nw_overflow_q | (wr_num_words_en & nw_full & ~nw_pop);

    case (state_q)
      ST_IDLE: begin
        // Commands stay queued while the link is down.
        if (~nw_empty & link_initialized) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        num_words_d  = nw_head;
        curr_words_d = '0;
        state_d      = (nw_head == '0) ? ST_IDLE : ST_PASS;
      end
      ST_PASS: begin
        if (accept) begin
          hold_data_d  = dramWrData_data;
          hold_valid_d = 1'b1;
          curr_words_d = words_inc;
          if (words_inc == CNT_W'(num_words_q)) begin
            if (sector_end(words_inc, SECTOR_LOG2)) begin
              fin_write_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              state_d     = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (space & link_initialized) begin
          hold_data_d  = '0;
          hold_valid_d = 1'b1;
          curr_words_d = words_inc;
          if (sector_end(words_inc, SECTOR_LOG2)) begin
            fin_write_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      hold_data_q   <= '0;
      hold_valid_q  <= 1'b0;
      curr_words_q  <= '0;
      num_words_q   <= '0;
      fin_write_q   <= 1'b0;
      nw_overflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_data_q   <= hold_data_d;
      hold_valid_q  <= hold_valid_d;
      curr_words_q  <= curr_words_d;
      num_words_q   <= num_words_d;
      fin_write_q   <= fin_write_d;
      nw_overflow_q <= nw_overflow_d;
    end
  end

endmodule

// File: tb/tb_wr_data_conv.sv
// Bench for wr_data_conv: source/sink models plus a scoreboard of expected
// HBA FIFO words (data followed by zero padding to a 128-word sector).
module tb_wr_data_conv;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dramWrData_data;
  logic        dramWrData_valid;
  logic        dramWrData_ready;
  logic [31:0] wdata;
  logic        wdata_write;
  logic        wdata_full;
  logic        link_initialized;
  logic [15:0] num_words;
  logic        wr_num_words_en;
  logic        nw_overflow;
  logic        fin_write;
  logic [1:0]  curr_state_de;
  logic [16:0] curr_words_de;

  int total = 0;
  int bad = 0;
  int push_cnt = 0;
  int fin_cnt = 0;
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  bit rand_valid = 1'b0;
  bit rand_full = 1'b0;

  always #5 clk = ~clk;

  wr_data_conv dut (
    .clk              (clk),
    .reset            (reset),
    .dramWrData_data  (dramWrData_data),
    .dramWrData_valid (dramWrData_valid),
    .dramWrData_ready (dramWrData_ready),
    .wdata            (wdata),
    .wdata_write      (wdata_write),
    .wdata_full       (wdata_full),
    .link_initialized (link_initialized),
    .num_words        (num_words),
    .wr_num_words_en  (wr_num_words_en),
    .nw_overflow      (nw_overflow),
    .fin_write        (fin_write),
    .curr_state_de    (curr_state_de),
    .curr_words_de    (curr_words_de)
  );

  // mcd data source: presents src_q head, retires it after a handshake.
  initial begin : source
    logic acc;
    dramWrData_valid = 1'b0;
    dramWrData_data  = '0;
    forever begin
      @(negedge clk); #2;
      acc = dramWrData_valid & dramWrData_ready;
      @(posedge clk); #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        dramWrData_valid = rand_valid ? ($urandom % 2 == 1) : 1'b1;
        dramWrData_data  = src_q[0];
      end else begin
        dramWrData_valid = 1'b0;
      end
    end
  end

  // HBA FIFO backpressure.
  initial begin : full_drv
    wdata_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      wdata_full = rand_full ? ($urandom % 2 == 1) : 1'b0;
    end
  end

  // Sink: every push is checked against the scoreboard.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk); #3;
      if (!reset && wdata_write) begin
        push_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wdata_unexpected got=%h want=none", wdata);
        end else begin
          e = exp_q.pop_front();
          if (wdata !== e) begin
            bad++;
            $display("FAIL wdata got=%h want=%h", wdata, e);
          end
        end
      end
      if (!reset && fin_write) fin_cnt++;
    end
  end

  task automatic add_cmd(input int n, input bit rnd, input logic [31:0] seed);
    int padded;
    logic [31:0] d;
    padded = ((n + 127) / 128) * 128;
    for (int i = 0; i < padded; i++) begin
      if (i < n) begin
        d = rnd ? $urandom : seed * 32'(i + 1);
        src_q.push_back(d);
        exp_q.push_back(d);
      end else begin
        exp_q.push_back('0);
      end
    end
  endtask

  task automatic enqueue(input logic [15:0] n);
    @(posedge clk); #1;
    num_words       = n;
    wr_num_words_en = 1'b1;
    @(posedge clk); #1;
    wr_num_words_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk); #4;
      if (exp_q.size() == 0 && src_q.size() == 0 && curr_state_de == 2'd0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout left=%0d want=0", nm, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    link_initialized = 1'b1;
    num_words = '0;
    wr_num_words_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #3;
    total++;
    if ({wdata, wdata_write, dramWrData_ready} !== 34'd0) begin
      bad++;
      $display("FAIL reset_data got=%h/%b/%b want=0", wdata, wdata_write, dramWrData_ready);
    end
    total++;
    if ({nw_overflow, fin_write} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags got=%b%b want=00", nw_overflow, fin_write);
    end
    total++;
    if ({curr_state_de, curr_words_de} !== 19'd0) begin
      bad++;
      $display("FAIL reset_state got=%0d/%0d want=0/0", curr_state_de, curr_words_de);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_cmd(input string nm, input int f0, input int p0, input int pushes);
    total++;
    if (fin_cnt - f0 !== 1) begin
      bad++;
      $display("FAIL %s_fin got=%0d want=1", nm, fin_cnt - f0);
    end
    total++;
    if (push_cnt - p0 !== pushes) begin
      bad++;
      $display("FAIL %s_pushes got=%0d want=%0d", nm, push_cnt - p0, pushes);
    end
  endtask

  task automatic test_basic();
    int f0 = fin_cnt;
    int p0 = push_cnt;
    add_cmd(4, 1'b0, 32'h11);
    enqueue(16'd4);
    wait_idle("basic", 1000);
    check_cmd("basic", f0, p0, 128);
  endtask

  task automatic test_full_sector();
    int f0 = fin_cnt;
    int p0 = push_cnt;
    add_cmd(128, 1'b0, 32'h0101_0101);
    enqueue(16'd128);
    wait_idle("sector", 1000);
    check_cmd("sector", f0, p0, 128);
    total++;
    if (curr_words_de !== 17'd128) begin
      bad++;
      $display("FAIL sector_words got=%0d want=128", curr_words_de);
    end
  endtask

  task automatic test_zero_then_one();
    int f0 = fin_cnt;
    int p0 = push_cnt;
    add_cmd(0, 1'b0, 32'h0);
    add_cmd(1, 1'b0, 32'hA5A5_0001);
    enqueue(16'd0);
    enqueue(16'd1);
    wait_idle("zero_one", 1000);
    check_cmd("zero_one", f0, p0, 128);
  endtask

  task automatic test_random();
    int f0 = fin_cnt;
    int p0 = push_cnt;
    rand_valid = 1'b1;
    rand_full  = 1'b1;
    add_cmd(130, 1'b1, 32'h0);
    enqueue(16'd130);
    wait_idle("random", 4000);
    rand_valid = 1'b0;
    rand_full  = 1'b0;
    check_cmd("random", f0, p0, 256);
  endtask

  task automatic test_link_drop();
    int f0 = fin_cnt;
    int p0 = push_cnt;
    bit hit = 1'b0;
    add_cmd(100, 1'b0, 32'h0001_0001);
    enqueue(16'd100);
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (curr_words_de == 17'd50 && curr_state_de == 2'd2) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL drop_reach got=%0d want=50", curr_words_de);
    end
    link_initialized = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      total++;
      if ({dramWrData_ready, wdata_write} !== 2'b00) begin
        bad++;
        $display("FAIL drop_quiet got=%b%b want=00", dramWrData_ready, wdata_write);
      end
      total++;
      if (curr_words_de !== 17'd50) begin
        bad++;
        $display("FAIL drop_hold got=%0d want=50", curr_words_de);
      end
    end
    @(negedge clk);
    link_initialized = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #3;
      if (curr_words_de != 17'd50) hit = 1'b1;
    end
    total++;
    if (curr_words_de !== 17'd51) begin
      bad++;
      $display("FAIL drop_resume got=%0d want=51", curr_words_de);
    end
    wait_idle("drop", 1000);
    check_cmd("drop", f0, p0, 128);
  endtask

  task automatic test_overflow_reset();
    int f0;
    int p0;
    bit hit = 1'b0;
    @(posedge clk); #1;
    link_initialized = 1'b0;
    for (int i = 0; i < 16; i++) begin
      num_words = 16'd1;
      wr_num_words_en = 1'b1;
      @(posedge clk); #1;
    end
    wr_num_words_en = 1'b0;
    @(negedge clk); #3;
    total++;
    if (nw_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_at16 got=%b want=0", nw_overflow);
    end
    @(posedge clk); #1;
    wr_num_words_en = 1'b1;
    @(posedge clk); #1;
    wr_num_words_en = 1'b0;
    @(negedge clk); #3;
    total++;
    if ({nw_overflow, curr_state_de} !== 3'b100) begin
      bad++;
      $display("FAIL ovf_at17 got=%b/%0d want=1/0", nw_overflow, curr_state_de);
    end
    // Reset discards the 16 queued commands and clears the sticky flag.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    link_initialized = 1'b1;
    @(negedge clk); #3;
    total++;
    if (nw_overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b want=0", nw_overflow);
    end
    repeat (40) @(negedge clk);
    total++;
    if (curr_state_de !== 2'd0) begin
      bad++;
      $display("FAIL queue_flushed got=%0d want=0", curr_state_de);
    end
    // Reset in the middle of padding.
    add_cmd(3, 1'b0, 32'h77);
    enqueue(16'd3);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (curr_state_de == 2'd3 && curr_words_de > 17'd10) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL pad_reach got=%0d want=3", curr_state_de);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk); #3;
    total++;
    if ({wdata, wdata_write, dramWrData_ready, fin_write, nw_overflow,
         curr_state_de, curr_words_de} !== 55'd0) begin
      bad++;
      $display("FAIL pad_reset got=%h/%b/%b/%b/%b/%0d/%0d want=all0", wdata, wdata_write,
               dramWrData_ready, fin_write, nw_overflow, curr_state_de, curr_words_de);
    end
    f0 = fin_cnt;
    p0 = push_cnt;
    add_cmd(5, 1'b0, 32'h0303_0303);
    enqueue(16'd5);
    wait_idle("after_reset", 1000);
    check_cmd("after_reset", f0, p0, 128);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_sector();
    test_zero_then_one();
    test_random();
    test_link_drop();
    test_overflow_reset();
    repeat (20) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
